snes_serializer: RTL and testbench

SNES_SERIALIZER -- requirements
Module: snes_serializer

---
 rtl/snes_pkg.sv | 14 +
 rtl/snes_edge_sync.sv | 32 +++
 rtl/snes_serializer.sv | 123 ++++++++++++
 tb/tb_snes_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// Shared types and default constants for the SNES controller-port serializer.
package snes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } port_state_e;

  localparam int SNES_FRAME_BITS  = 16;
  localparam int SNES_SYNC_STAGES = 2;

endpackage

// File: rtl/snes_edge_sync.sv
// Purpose: brings one asynchronous console pin into the clock domain and flags its edges.
// Latency: an edge sampled on cycle N is flagged combinationally after SYNC_STAGES edges.
// Backpressure: none, every pin transition is observed.
module snes_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/snes_serializer.sv
// Purpose: emulates NUM_PORTS SNES controllers, shifting button bits out on console clocks.
// Latency: acts on a pin edge SYNC_STAGES+1 cycles after it is sampled; outputs are registered.
// Backpressure: none, the console drives timing; excess clocks raise a sticky overrun.
module snes_serializer
  import snes_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int FRAME_BITS  = SNES_FRAME_BITS,
  parameter int SYNC_STAGES = SNES_SYNC_STAGES
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            snes_latch,
  input  logic [NUM_PORTS-1:0]            snes_clk,
  input  logic [NUM_PORTS*FRAME_BITS-1:0] d,
  output logic [NUM_PORTS-1:0]            snes_out,
  output logic [NUM_PORTS-1:0]            frame_done,
  output logic [NUM_PORTS-1:0]            overrun
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  logic latch_lvl;
  logic latch_rise;
  logic latch_fall;

  snes_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_latch_sync (
    .clock  (clock),
    .reset  (reset),
    .pin_i  (snes_latch),
    .level_o(latch_lvl),
    .rise_o (latch_rise),
    .fall_o (latch_fall)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic                  clk_rise;
    logic                  clk_level_unused;
    logic                  clk_fall_unused;
    logic [FRAME_BITS-1:0] d_slice;
    logic [FRAME_BITS-1:0] shift_d;
    logic                  clk_ok;

    port_state_e           state_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [CW-1:0]         cnt_q;
    logic                  out_q;
    logic                  done_q;
    logic                  ovr_q;

    snes_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_clk_sync (
      .clock  (clock),
      .reset  (reset),
      .pin_i  (snes_clk[p]),
      .level_o(clk_level_unused),
      .rise_o (clk_rise),
      .fall_o (clk_fall_unused)
    );

    assign d_slice = d[p*FRAME_BITS +: FRAME_BITS];
    assign shift_d = {1'b0, shift_q[FRAME_BITS-1:1]};
    // Console clocks are meaningless while the latch is held high.
    assign clk_ok  = clk_rise & ~latch_lvl;

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
        shift_q <= '0;
        cnt_q   <= '0;
        out_q   <= 1'b1;
        done_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (latch_rise) begin
          // A new latch restarts the frame from any state and swallows a coincident clock.
          state_q <= LATCHED;
          shift_q <= d_slice;
          cnt_q   <= '0;
          out_q   <= ~d_slice[0];
        end else begin
          case (state_q)
            IDLE: begin
              state_q <= IDLE;
            end
            LATCHED: begin
              if (latch_fall) state_q <= SHIFT;
            end
            SHIFT: begin
              if (clk_ok) begin
                shift_q <= shift_d;
                cnt_q   <= cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                  state_q <= DONE;
                  out_q   <= 1'b1;
                  done_q  <= 1'b1;
                end else begin
                  out_q   <= ~shift_d[0];
                end
              end
            end
            DONE: begin
              if (clk_ok) ovr_q <= 1'b1;
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end
      end
    end

    assign snes_out[p]   = out_q;
    assign frame_done[p] = done_q;
    assign overrun[p]    = ovr_q;
  end

endmodule

// File: tb/tb_snes_serializer.sv
// Directed bench for snes_serializer: default 2x16 instance plus a 4x8 instance for reset-mid-frame.
module tb_snes_serializer;

  logic        clock;
  logic        reset;
  logic        latch;
  logic [1:0]  sclk;
  logic [31:0] d;
  logic [1:0]  out;
  logic [1:0]  fd;
  logic [1:0]  ovr;

  logic        reset8;
  logic        latch8;
  logic [3:0]  sclk8;
  logic [31:0] d8;
  logic [3:0]  out8;
  logic [3:0]  fd8;
  logic [3:0]  ovr8;

  int checks;
  int errors;
  int fd0_cnt;
  int fd1_cnt;
  int fd8_tot;

  snes_serializer dut (
    .clock     (clock),
    .reset     (reset),
    .snes_latch(latch),
    .snes_clk  (sclk),
    .d         (d),
    .snes_out  (out),
    .frame_done(fd),
    .overrun   (ovr)
  );

  snes_serializer #(
    .NUM_PORTS  (4),
    .FRAME_BITS (8),
    .SYNC_STAGES(2)
  ) dut8 (
    .clock     (clock),
    .reset     (reset8),
    .snes_latch(latch8),
    .snes_clk  (sclk8),
    .d         (d8),
    .snes_out  (out8),
    .frame_done(fd8),
    .overrun   (ovr8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      fd0_cnt += int'(fd[0]);
      fd1_cnt += int'(fd[1]);
      fd8_tot += $countones(fd8);
    end
  endtask

  task automatic pulse_latch();
    latch = 1'b1;
    wait_cyc(4);
    latch = 1'b0;
    wait_cyc(4);
  endtask

  task automatic pulse_clk(input int p);
    sclk[p] = 1'b1;
    wait_cyc(4);
    sclk[p] = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++;
    if (out !== 2'b11) begin errors++; $display("FAIL reset_out: got %b expected 11", out); end
    checks++;
    if (fd !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", fd); end
    checks++;
    if (ovr !== 2'b00) begin errors++; $display("FAIL reset_ovr: got %b expected 00", ovr); end
    checks++;
    if (out8 !== 4'hf) begin errors++; $display("FAIL reset_out8: got %b expected 1111", out8); end
    // Latch held high through reset release must be seen as one rise, SYNC_STAGES+1 cycles later.
    d     = {16'h0000, 16'h0001};
    latch = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(2);
    checks++;
    if (out !== 2'b11) begin errors++; $display("FAIL release_early: got %b expected 11", out); end
    wait_cyc(1);
    checks++;
    if (out !== 2'b10) begin errors++; $display("FAIL release_latch: got %b expected 10", out); end
    latch = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_single_frame();
    int f0;
    d = {16'h0000, 16'h0001};
    pulse_latch();
    f0 = fd0_cnt;
    checks++;
    if (out[0] !== 1'b0) begin errors++; $display("FAIL single_bit0: got %b expected 0", out[0]); end
    for (int i = 1; i < 16; i++) begin
      pulse_clk(0);
      checks++;
      if (out[0] !== 1'b1) begin errors++; $display("FAIL single_bit%0d: got %b expected 1", i, out[0]); end
    end
    checks++;
    if (fd0_cnt !== f0) begin errors++; $display("FAIL single_early_done: got %0d pulses expected 0", fd0_cnt - f0); end
    pulse_clk(0);
    checks++;
    if (fd0_cnt !== f0 + 1) begin errors++; $display("FAIL single_done: got %0d pulses expected 1", fd0_cnt - f0); end
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("FAIL single_done_out: got %b expected 1", out[0]); end
  endtask

  task automatic test_overrun();
    pulse_clk(0);
    checks++;
    if (ovr !== 2'b01) begin errors++; $display("FAIL overrun_flag: got %b expected 01", ovr); end
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("FAIL overrun_out: got %b expected 1", out[0]); end
  endtask

  task automatic test_interleave();
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  exp;
    int f0;
    int f1;
    a = 16'hA5A5;
    b = 16'h0F0F;
    d = {b, a};
    pulse_latch();
    f0 = fd0_cnt;
    f1 = fd1_cnt;
    for (int i = 0; i < 16; i++) begin
      exp = {~b[i], ~a[i]};
      checks++;
      if (out !== exp) begin errors++; $display("FAIL interleave_bit%0d: got %b expected %b", i, out, exp); end
      if (i % 2 == 0) begin
        pulse_clk(0);
        pulse_clk(1);
      end else begin
        pulse_clk(1);
        pulse_clk(0);
      end
    end
    checks++;
    if ((fd0_cnt - f0) !== 1 || (fd1_cnt - f1) !== 1) begin
      errors++;
      $display("FAIL interleave_done: got %0d/%0d pulses expected 1/1", fd0_cnt - f0, fd1_cnt - f1);
    end
    checks++;
    if (ovr !== 2'b01) begin errors++; $display("FAIL interleave_ovr: got %b expected 01", ovr); end
  endtask

  task automatic test_abort();
    int f0;
    d[15:0] = 16'h1234;
    pulse_latch();
    for (int i = 0; i < 5; i++) pulse_clk(0);
    checks++;
    if (out[0] !== 1'b0) begin errors++; $display("FAIL abort_bit5: got %b expected 0", out[0]); end
    f0 = fd0_cnt;
    d[15:0] = 16'h0002;
    pulse_latch();
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("FAIL abort_reload: got %b expected 1", out[0]); end
    checks++;
    if (fd0_cnt !== f0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", fd0_cnt - f0); end
    pulse_clk(0);
    checks++;
    if (out[0] !== 1'b0) begin errors++; $display("FAIL abort_bit1: got %b expected 0", out[0]); end
    for (int i = 0; i < 14; i++) pulse_clk(0);
    checks++;
    if (fd0_cnt !== f0) begin errors++; $display("FAIL abort_early_done: got %0d pulses expected 0", fd0_cnt - f0); end
    pulse_clk(0);
    checks++;
    if (fd0_cnt !== f0 + 1) begin errors++; $display("FAIL abort_full_frame: got %0d pulses expected 1", fd0_cnt - f0); end
  endtask

  task automatic test_collision();
    int f0;
    d[15:0] = 16'h0002;
    f0 = fd0_cnt;
    latch   = 1'b1;
    sclk[0] = 1'b1;
    wait_cyc(4);
    sclk[0] = 1'b0;
    wait_cyc(4);
    latch   = 1'b0;
    wait_cyc(4);
    checks++;
    if (out[0] !== 1'b1) begin errors++; $display("FAIL collide_bit0: got %b expected 1", out[0]); end
    pulse_clk(0);
    checks++;
    if (out[0] !== 1'b0) begin errors++; $display("FAIL collide_bit1: got %b expected 0", out[0]); end
    for (int i = 0; i < 14; i++) pulse_clk(0);
    checks++;
    if (fd0_cnt !== f0) begin errors++; $display("FAIL collide_early_done: got %0d pulses expected 0", fd0_cnt - f0); end
    pulse_clk(0);
    checks++;
    if (fd0_cnt !== f0 + 1) begin errors++; $display("FAIL collide_done: got %0d pulses expected 1", fd0_cnt - f0); end
  endtask

  task automatic test_reset_mid();
    reset8 = 1'b0;
    d8     = 32'h08080808;
    wait_cyc(2);
    latch8 = 1'b1;
    wait_cyc(4);
    latch8 = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < 3; i++) begin
      sclk8 = 4'hf;
      wait_cyc(4);
      sclk8 = 4'h0;
      wait_cyc(4);
    end
    checks++;
    if (out8 !== 4'h0) begin errors++; $display("FAIL mid_bit3: got %b expected 0000", out8); end
    reset8 = 1'b1;
    wait_cyc(1);
    checks++;
    if (out8 !== 4'hf) begin errors++; $display("FAIL mid_reset_out: got %b expected 1111", out8); end
    checks++;
    if (ovr8 !== 4'h0) begin errors++; $display("FAIL mid_reset_ovr: got %b expected 0000", ovr8); end
    checks++;
    if (fd8_tot !== 0) begin errors++; $display("FAIL mid_reset_done: got %0d pulses expected 0", fd8_tot); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    fd0_cnt = 0;
    fd1_cnt = 0;
    fd8_tot = 0;
    reset   = 1'b1;
    latch   = 1'b0;
    sclk    = 2'b00;
    d       = '0;
    reset8  = 1'b1;
    latch8  = 1'b0;
    sclk8   = 4'h0;
    d8      = '0;

    test_reset();
    test_single_frame();
    test_overrun();
    test_interleave();
    test_abort();
    test_collision();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
